// File: rtl/mpu_regs_arbiter_pkg.sv
// Shared MPU register-arbiter definitions: FSM encoding, requester ids, index width.
package mpu_regs_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

  localparam int REQ_EXEC = 0;
  localparam int REQ_HOST = 1;

  function automatic int iw_of(input int nb_reg);
    return nb_reg / 8 + 1;
  endfunction

  function automatic arb_state_t own_state(input logic n);
    return n ? ST_OWN1 : ST_OWN0;
  endfunction

endpackage

// File: rtl/mpu_regs_arbiter_rr_grant.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one not granted last.
module mpu_rr_grant
  import mpu_regs_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = valid;
    if (&valid) begin
      grant = '0;
      grant[last_grant ? REQ_EXEC : REQ_HOST] = 1'b1;
    end
  end

endmodule

// File: rtl/mpu_regs_arbiter.sv
// Arbitrates execute-unit and host writes into the MPU register file, one registered write port.
module mpu_regs_arbiter
  import mpu_regs_arbiter_pkg::*;
#(
  parameter  int nb_reg = 32,
  parameter  int cnt_w  = 16,
  localparam int IW     = iw_of(nb_reg)
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             stall,
  input  logic [1:0]       rq_valid,
  input  logic [1:0]       rq_lock,
  output logic [1:0]       rq_ready,
  input  logic [IW-1:0]    rq0_idx,
  input  logic [63:0]      rq0_data,
  input  logic [2:0]       rq0_sel,
  input  logic [2:0]       rq0_r_sel,
  input  logic [1:0]       rq0_size,
  input  logic [IW-1:0]    rq1_idx,
  input  logic [63:0]      rq1_data,
  input  logic [2:0]       rq1_sel,
  input  logic [2:0]       rq1_r_sel,
  input  logic [1:0]       rq1_size,
  output logic [IW-1:0]    w_idx,
  output logic [63:0]      w_data,
  output logic [2:0]       w_sel,
  output logic [2:0]       w_r_sel,
  output logic [1:0]       w_size,
  output logic             we,
  output logic             en,
  output logic [1:0]       owner,
  output logic [cnt_w-1:0] wr_cnt0,
  output logic [cnt_w-1:0] wr_cnt1
);

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [63:0]   data;
    logic [2:0]    sel;
    logic [2:0]    r_sel;
    logic [1:0]    size;
  } wr_req_t;

  arb_state_t                 state;
  logic                       last_grant;
  logic                       cur, oth;
  logic [1:0]                 rr_gnt, xfer;
  wr_req_t [1:0]              rq;
  wr_req_t                    w_q;
  logic [1:0][cnt_w-1:0]      cnt;

  assign rq[0] = {rq0_idx, rq0_data, rq0_sel, rq0_r_sel, rq0_size};
  assign rq[1] = {rq1_idx, rq1_data, rq1_sel, rq1_r_sel, rq1_size};

  assign cur      = (state == ST_OWN1);
  assign oth      = ~cur;
  assign en       = ~stall;
  assign rq_ready = {state == ST_OWN1, state == ST_OWN0} & {2{~stall}};
  assign xfer     = rq_valid & rq_ready;
  assign owner    = {state == ST_OWN1, state == ST_OWN0};

  mpu_rr_grant u_rr (
    .valid      (rq_valid),
    .last_grant (last_grant),
    .grant      (rr_gnt)
  );

  // An unlocked owner yields after every accepted transfer if the other side is waiting.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
    end else if (!stall) begin
      if (|xfer) last_grant <= xfer[1];
      case (state)
        ST_IDLE: begin
          if (rr_gnt[0])      state <= ST_OWN0;
          else if (rr_gnt[1]) state <= ST_OWN1;
        end
        ST_OWN0, ST_OWN1: begin
          if ((xfer[cur] && !rq_lock[cur] && rq_valid[oth]) ||
              (!rq_valid[cur] && !rq_lock[cur]))
            state <= rq_valid[oth] ? own_state(oth) : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      we  <= 1'b0;
      w_q <= '0;
    end else if (!stall) begin
      we <= |xfer;
      if (|xfer) w_q <= rq[cur];
    end
  end

  assign {w_idx, w_data, w_sel, w_r_sel, w_size} = w_q;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt <= '0;
    end else begin
      for (int n = 0; n < 2; n++)
        if (xfer[n] && cnt[n] != '1) cnt[n] <= cnt[n] + cnt_w'(1);
    end
  end

  assign wr_cnt0 = cnt[0];
  assign wr_cnt1 = cnt[1];

endmodule

// File: tb/tb_mpu_regs_arbiter.sv
// Scoreboard bench for mpu_regs_arbiter: accepted writes are queued and matched on commit.
module tb_mpu_regs_arbiter;

  localparam int IW = 32 / 8 + 1;

  logic          sys_clk = 1'b0;
  logic          sys_rst, stall;
  logic [1:0]    rq_valid, rq_lock, rq_ready;
  logic [IW-1:0] rq0_idx, rq1_idx, w_idx;
  logic [63:0]   rq0_data, rq1_data, w_data;
  logic [2:0]    rq0_sel, rq0_r_sel, rq1_sel, rq1_r_sel, w_sel, w_r_sel;
  logic [1:0]    rq0_size, rq1_size, w_size, owner;
  logic          we, en;
  logic [15:0]   wr_cnt0, wr_cnt1;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [63:0]   data;
    logic [2:0]    sel;
    logic [2:0]    r_sel;
    logic [1:0]    size;
  } wr_t;

  wr_t sb_q[$];
  wr_t sb_exp;
  int  acc_log[$];
  int  acc_cnt0;
  int  checks   = 0;
  int  failures = 0;
  bit  hold     = 1'b0;

  always #5 sys_clk = ~sys_clk;

  mpu_regs_arbiter dut (
    .sys_clk, .sys_rst, .stall, .rq_valid, .rq_lock, .rq_ready,
    .rq0_idx, .rq0_data, .rq0_sel, .rq0_r_sel, .rq0_size,
    .rq1_idx, .rq1_data, .rq1_sel, .rq1_r_sel, .rq1_size,
    .w_idx, .w_data, .w_sel, .w_r_sel, .w_size,
    .we, .en, .owner, .wr_cnt0, .wr_cnt1
  );

  // Fresh payloads every cycle unless a test pins them.
  initial begin
    forever begin
      @(posedge sys_clk); #2;
      if (!hold) begin
        rq0_idx = IW'($urandom);  rq0_data = {$urandom, $urandom};
        rq0_sel = 3'($urandom);   rq0_r_sel = 3'($urandom); rq0_size = 2'($urandom);
        rq1_idx = IW'($urandom);  rq1_data = {$urandom, $urandom};
        rq1_sel = 3'($urandom);   rq1_r_sel = 3'($urandom); rq1_size = 2'($urandom);
      end
    end
  end

  // Commit = we while enabled; accept = valid & ready seen before the edge.
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      checks++;
      if (&rq_ready) begin
        failures++;
        $display("FAIL ready_onehot got=%b", rq_ready);
      end
      if (we && en) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL sb_spurious_we got we=1 expected no write");
        end else begin
          sb_exp = sb_q.pop_front();
          if ({w_idx, w_data, w_sel, w_r_sel, w_size} !== sb_exp) begin
            failures++;
            $display("FAIL sb_write got=%h expected=%h",
                     {w_idx, w_data, w_sel, w_r_sel, w_size}, sb_exp);
          end
        end
      end
      if (rq_valid[0] && rq_ready[0]) begin
        sb_q.push_back({rq0_idx, rq0_data, rq0_sel, rq0_r_sel, rq0_size});
        acc_log.push_back(0);
        acc_cnt0++;
      end
      if (rq_valid[1] && rq_ready[1]) begin
        sb_q.push_back({rq1_idx, rq1_data, rq1_sel, rq1_r_sel, rq1_size});
        acc_log.push_back(1);
      end
    end
  end

  task automatic apply_reset();
    @(posedge sys_clk); #1;
    rq_valid = '0; rq_lock = '0; stall = 1'b0;
    #2 sys_rst = 1'b1;
    sb_q.delete();
    repeat (2) @(posedge sys_clk);
    #3 sys_rst = 1'b0;
    acc_log.delete();
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; stall = 1'b0; rq_lock = '0; rq_valid = 2'b11;
    #1;
    checks++; if (we !== 1'b0)      begin failures++; $display("FAIL rst_we got=%b expected=0", we); end
    checks++; if (owner !== 2'b00)  begin failures++; $display("FAIL rst_owner got=%b expected=00", owner); end
    checks++; if (rq_ready !== 2'b00) begin failures++; $display("FAIL rst_ready got=%b expected=00", rq_ready); end
    checks++; if ({wr_cnt0, wr_cnt1} !== 32'h0) begin failures++; $display("FAIL rst_cnt got=%h/%h expected=0", wr_cnt0, wr_cnt1); end
    checks++; if ({w_idx, w_data, w_size} !== '0) begin failures++; $display("FAIL rst_wfields got=%h/%h expected=0", w_idx, w_data); end
    repeat (2) @(posedge sys_clk);
    #3 sys_rst = 1'b0;
    @(negedge sys_clk);
    checks++; if (rq_ready !== 2'b00) begin failures++; $display("FAIL rel_ready got=%b expected=00", rq_ready); end
    checks++; if (we !== 1'b0) begin failures++; $display("FAIL rel_we got=%b expected=0", we); end
  endtask

  task automatic test_alternate();
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk);
      if (i == 0) begin
        checks++; if (owner !== 2'b01) begin failures++; $display("FAIL alt_first_owner got=%b expected=01", owner); end
      end else begin
        checks++; if (we !== 1'b1) begin failures++; $display("FAIL alt_we cyc=%0d got=%b expected=1", i, we); end
      end
    end
    checks++;
    if (acc_log.size() < 4) begin
      failures++; $display("FAIL alt_count got=%0d expected>=4", acc_log.size());
    end else if (acc_log[0] != 0 || acc_log[1] != 1 || acc_log[2] != 0 || acc_log[3] != 1) begin
      failures++; $display("FAIL alt_order got=%0d%0d%0d%0d expected=0101", acc_log[0], acc_log[1], acc_log[2], acc_log[3]);
    end
    @(posedge sys_clk); #1 rq_valid = '0;
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic test_lock_burst();
    int n = 0;
    apply_reset();
    @(posedge sys_clk); #1 rq_valid = 2'b10; rq_lock = 2'b10;
    @(posedge sys_clk); #1 rq_valid = 2'b11;
    for (int c = 0; c < 20 && n < 4; c++) begin
      @(negedge sys_clk); #1;
      if (rq_valid[1] && rq_ready[1]) n++;
    end
    checks++; if (n != 4) begin failures++; $display("FAIL lock_timeout got=%0d expected=4 host accepts", n); end
    checks++; if (owner !== 2'b10) begin failures++; $display("FAIL lock_owner got=%b expected=10", owner); end
    @(posedge sys_clk); #1 rq_valid = 2'b01; rq_lock = '0;
    repeat (4) @(negedge sys_clk);
    checks++;
    if (acc_log.size() < 5) begin
      failures++; $display("FAIL lock_count got=%0d expected>=5", acc_log.size());
    end else if (acc_log[0] != 1 || acc_log[1] != 1 || acc_log[2] != 1 || acc_log[3] != 1 || acc_log[4] != 0) begin
      failures++; $display("FAIL lock_order got=%0d%0d%0d%0d%0d expected=11110", acc_log[0], acc_log[1], acc_log[2], acc_log[3], acc_log[4]);
    end
    checks++; if (wr_cnt1 !== 16'd4) begin failures++; $display("FAIL lock_cnt1 got=%0d expected=4", wr_cnt1); end
    @(posedge sys_clk); #1 rq_valid = '0;
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic test_single_write();
    @(posedge sys_clk); #1;
    hold = 1'b1;
    rq0_idx = 5'd5; rq0_data = 64'hDEADBEEF_00000001; rq0_size = 2'd2;
    rq0_sel = 3'd3; rq0_r_sel = 3'd6; rq_valid = 2'b01;
    @(negedge sys_clk);
    checks++; if (rq_ready !== 2'b00) begin failures++; $display("FAIL sw_grant_cycle got=%b expected=00", rq_ready); end
    @(negedge sys_clk);
    checks++; if (rq_ready !== 2'b01) begin failures++; $display("FAIL sw_ready got=%b expected=01", rq_ready); end
    @(posedge sys_clk); #1 rq_valid = '0;
    @(negedge sys_clk);
    checks++; if (we !== 1'b1) begin failures++; $display("FAIL sw_we got=%b expected=1", we); end
    checks++;
    if (w_idx !== 5'd5 || w_data !== 64'hDEADBEEF_00000001 || w_size !== 2'd2 || w_sel !== 3'd3 || w_r_sel !== 3'd6) begin
      failures++; $display("FAIL sw_fields got=%h/%h/%h expected=05/deadbeef00000001/2", w_idx, w_data, w_size);
    end
    @(negedge sys_clk);
    checks++; if (we !== 1'b0) begin failures++; $display("FAIL sw_we_drop got=%b expected=0", we); end
  endtask

  task automatic test_stall();
    @(posedge sys_clk); #1;
    rq0_data = 64'h0123_4567_89AB_CDEF; rq_valid = 2'b01;
    repeat (2) @(negedge sys_clk);
    @(posedge sys_clk); #1 stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      checks++;
      if (we !== 1'b1 || en !== 1'b0 || rq_ready !== 2'b00 || w_data !== 64'h0123_4567_89AB_CDEF) begin
        failures++; $display("FAIL stall_hold cyc=%0d got we=%b en=%b rdy=%b data=%h expected 1/0/00/0123456789abcdef", i, we, en, rq_ready, w_data);
      end
    end
    @(posedge sys_clk); #1 stall = 1'b0; rq_valid = '0;
    @(negedge sys_clk);
    checks++;
    if (we !== 1'b1 || en !== 1'b1 || w_data !== 64'h0123_4567_89AB_CDEF) begin
      failures++; $display("FAIL stall_commit got we=%b en=%b data=%h expected 1/1/0123456789abcdef", we, en, w_data);
    end
    @(negedge sys_clk);
    checks++; if (we !== 1'b0) begin failures++; $display("FAIL stall_we_drop got=%b expected=0", we); end
    hold = 1'b0;
  endtask

  task automatic test_saturate();
    bit done = 1'b0;
    apply_reset();
    @(posedge sys_clk); #1 acc_cnt0 = 0; rq_valid = 2'b01;
    for (int c = 0; c < 70000 && !done; c++) begin
      @(negedge sys_clk); #1;
      if (acc_cnt0 == 65535) begin
        checks++; if (wr_cnt0 !== 16'hFFFE) begin failures++; $display("FAIL sat_pre got=%h expected=fffe", wr_cnt0); end
      end
      if (acc_cnt0 >= 65538) done = 1'b1;
    end
    checks++; if (!done) begin failures++; $display("FAIL sat_timeout got=%0d expected=65538 accepts", acc_cnt0); end
    @(posedge sys_clk); #1 rq_valid = '0;
    repeat (2) @(negedge sys_clk);
    checks++; if (wr_cnt0 !== 16'hFFFF) begin failures++; $display("FAIL sat_cnt0 got=%h expected=ffff", wr_cnt0); end
    checks++; if (wr_cnt1 !== 16'h0) begin failures++; $display("FAIL sat_cnt1 got=%h expected=0", wr_cnt1); end
  endtask

  task automatic test_async_reset();
    @(posedge sys_clk); #1 rq_valid = 2'b11;
    repeat (4) @(negedge sys_clk);
    checks++; if (we !== 1'b1) begin failures++; $display("FAIL ar_pre_we got=%b expected=1", we); end
    @(posedge sys_clk); #3 sys_rst = 1'b1;
    sb_q.delete();
    #1;
    checks++; if (we !== 1'b0 || owner !== 2'b00) begin failures++; $display("FAIL ar_we_owner got=%b/%b expected=0/00", we, owner); end
    checks++; if (wr_cnt0 !== 16'h0 || wr_cnt1 !== 16'h0) begin failures++; $display("FAIL ar_cnt got=%h/%h expected=0/0", wr_cnt0, wr_cnt1); end
    checks++; if (rq_ready !== 2'b00) begin failures++; $display("FAIL ar_ready got=%b expected=00", rq_ready); end
    @(posedge sys_clk); #3 sys_rst = 1'b0;
    @(negedge sys_clk);
    checks++; if (we !== 1'b0 || rq_ready !== 2'b00) begin failures++; $display("FAIL ar_release got we=%b rdy=%b expected 0/00", we, rq_ready); end
    @(posedge sys_clk); #1 rq_valid = '0;
    repeat (2) @(negedge sys_clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alternate();
    test_lock_burst();
    test_single_write();
    test_stall();
    test_saturate();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mpu_regs_arbiter.md
MPU_REGS_ARBITER -- requirements
Module: mpu_regs_arbiter

Interface
REQ-001 Parameter: nb_reg, 32, number of 64-bit registers; index width IW = nb_reg/8+1 bits.
REQ-002 Parameter: cnt_w, 16, width of the per-requester accepted-write counters.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset, with ports named as follows.
REQ-004 sys_clk  in  1  sole clock, rising edge.
REQ-005 sys_rst  in  1  asynchronous, active-high reset.
REQ-006 stall  in  1  register-file pipeline stall; output stage frozen while 1.
REQ-007 rq_valid  in  2  per-requester write request (bit0 = execute unit, bit1 = host/debug).
REQ-008 rq_lock  in  2  per-requester burst lock; keeps the grant while asserted.
REQ-009 rq_ready  out  2  per-requester accept; a transfer occurs when valid and ready are both 1.
REQ-010 rqN_idx/rqN_data/rqN_sel/rqN_r_sel/rqN_size  in  IW/64/3/3/2  write fields of requester N (N=0,1).
REQ-011 w_idx/w_data/w_sel/w_r_sel/w_size  out  IW/64/3/3/2  registered register-file write fields.
REQ-012 we  out  1  register-file write strobe, registered.
REQ-013 en  out  1  register-file enable = not stall.
REQ-014 owner  out  2  one-hot current grant holder; 0 when idle.
REQ-015 wr_cnt0/wr_cnt1  out  cnt_w  accepted-write count per requester.

Function
REQ-016 FSM states: IDLE, OWN0, OWN1; state register updates only when stall = 0.
REQ-017 IDLE: no rq_valid -> stay; exactly one valid -> OWN of that requester; both valid -> OWN of the requester not equal to last_grant (round-robin).
REQ-018 OWNn: while rq_valid[n] or rq_lock[n] is 1 -> stay in OWNn.
REQ-019 OWNn: if rq_valid[n] = 0 and rq_lock[n] = 0 -> OWN of the other requester if it is valid, else IDLE.
REQ-020 OWNn without lock: after each accepted transfer, if the other requester is valid, move to the other OWN (one transfer per turn).
REQ-021 rq_ready[n] = 1 only when state = OWNn and stall = 0; rq_ready is combinational from state and stall; both bits are never 1 together.
REQ-022 The grant-issuing cycle (IDLE -> OWNn) SHALL accept nothing; first acceptance is the next cycle (arbitration latency 1).
REQ-023 On accept: the write fields are registered into w_* and we = 1 on the next cycle (write latency 1); otherwise we = 0 next cycle.
REQ-024 stall = 1: w_*, we, state, counters and last_grant hold; en = 0 so the held write is not committed.
REQ-025 last_grant SHALL update to n on every accepted transfer of requester n.
REQ-026 wr_cntN increments by 1 per accepted transfer of requester N and saturates at 2^cnt_w - 1 (no wrap).
REQ-027 A lock held with rq_valid = 0 keeps OWNn with rq_ready[n] = 1; the other requester waits indefinitely (by design).
REQ-028 w_* fields SHALL be passed through unmodified; size/select interpretation is the register file's.

Reset
REQ-029 On sys_rst = 1 (asynchronous): state = IDLE, last_grant = 1, we = 0, w_* = 0, wr_cnt0 = wr_cnt1 = 0, owner = 0.
REQ-030 Reset mid-burst SHALL discard any in-flight write; no we pulse on the first cycle after reset release.
REQ-031 rq_ready = 0 during reset and in the first cycle after release.

Structure
REQ-032 The shared MPU package SHALL hold the FSM state encoding, requester index constants (REQ_EXEC = 0, REQ_HOST = 1) and the IW width function.
REQ-033 One sub-module, mpu_rr_grant, SHALL implement the 2-way round-robin selection from valid bits and last_grant.
REQ-034 Synthesizable RTL, single always block per register group, no latches.

Verification
REQ-035 Both valid from IDLE after reset, no lock -> OWN0 first (last_grant = 1), then transfers alternate 0,1,0,1; we asserted every cycle after the first grant.
REQ-036 rq_lock[1] = 1 with 4 host writes while requester 0 is valid -> 4 consecutive host writes, then grant passes to 0; wr_cnt1 = 4.
REQ-037 Single write idx=5, data=64'hDEADBEEF_00000001, size=2 -> w_* equal to those inputs and we = 1 exactly one cycle after the accept.
REQ-038 stall = 1 for 3 cycles with a write pending on w_* -> w_*/we held, en = 0, rq_ready = 0; the write commits in the first cycle after stall drops.
REQ-039 wr_cnt0 preloaded near maximum by 2^cnt_w + 2 accepted writes -> wr_cnt0 = 16'hFFFF, no wrap.
REQ-040 sys_rst asserted mid-burst, asynchronously between clock edges -> we = 0 and owner = 0 immediately; counters = 0.
